buf_alloc_ctrl: RTL

//  Sequences the 4-entry LFU buffer-replacement finder (lfu) for NREQ requesters.

---
 rtl/buf_alloc_pkg.sv | 16 +
 rtl/buf_alloc_ctrl_rr_arbiter.sv | 37 +++
 rtl/buf_alloc_ctrl.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/buf_alloc_pkg.sv
// Shared constants and FSM encoding for the buffer-allocation controller.
// The buffer array is fixed at four entries, which sets the buffer-number width.
package buf_alloc_pkg;

  localparam int NBUF  = 4;
  localparam int BUF_W = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOOKUP = 3'd1,
    ST_VICTIM = 3'd2,
    ST_FILL   = 3'd3,
    ST_GRANT  = 3'd4
  } state_t;

endpackage

// File: rtl/buf_alloc_ctrl_rr_arbiter.sv
// Round-robin arbiter: the requester at or after ptr (cyclically) wins.
// Returns both a one-hot grant and the winner's index.
module rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int PTR_W = 2
) (
  input  logic [NREQ-1:0]  i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [NREQ-1:0]  o_gnt,
  output logic [PTR_W-1:0] o_gnt_idx
);

  int w_best;
  int w_dist;

  // Priority is the cyclic distance from the pointer; the smallest distance wins.
  always_comb begin
    w_best    = NREQ;
    w_dist    = 0;
    o_gnt_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_dist = (i >= int'(i_ptr)) ? (i - int'(i_ptr)) : (i + NREQ - int'(i_ptr));
      if (i_req[i] && (w_dist < w_best)) begin
        w_best    = w_dist;
        o_gnt_idx = PTR_W'(i);
      end
    end
  end

  always_comb begin
    o_gnt = '0;
    for (int i = 0; i < NREQ; i++) begin
      o_gnt[i] = (|i_req) && (o_gnt_idx == PTR_W'(i));
    end
  end

endmodule

// File: rtl/buf_alloc_ctrl.sv
// Serves one requester at a time: tag lookup over four buffers, free-buffer or
// LFU-victim selection on a miss, a fill handshake, then a one-cycle grant.
module buf_alloc_ctrl
  import buf_alloc_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TAG_W   = 8,
  parameter int LFU_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*TAG_W-1:0] req_tag,
  input  logic                  inv_all,
  output logic [NREQ-1:0]       gnt,
  output logic [BUF_W-1:0]      gnt_buf,
  output logic                  gnt_hit,
  output logic                  fill_req,
  output logic [BUF_W-1:0]      fill_buf,
  output logic [TAG_W-1:0]      fill_tag,
  input  logic                  fill_ack,
  output logic                  lfu_new_buf_req,
  output logic                  lfu_ref_vld,
  output logic [BUF_W-1:0]      lfu_ref_buf_numbr,
  input  logic [BUF_W-1:0]      lfu_buf_num_replc,
  output logic                  busy,
  output logic [2:0]            dbg_state
);

  localparam int PTR_W = $clog2(NREQ);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] r_win_idx;
  logic [TAG_W-1:0] r_tag;
  logic [BUF_W-1:0] r_buf;
  logic             r_hit;
  logic [1:0]       r_cnt;
  logic [NBUF-1:0]  r_valid;
  logic [TAG_W-1:0] r_tags [NBUF];

  logic [NREQ-1:0]  w_arb_gnt;
  logic [PTR_W-1:0] w_arb_idx;
  logic [TAG_W-1:0] w_sel_tag;
  logic             w_req_any;
  logic             w_hit;
  logic [BUF_W-1:0] w_hit_buf;
  logic             w_free;
  logic [BUF_W-1:0] w_free_buf;
  logic             w_victim_done;

  assign w_req_any     = |req;
  assign w_victim_done = (r_cnt == 2'(LFU_LAT));

  rr_arbiter #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_rr_arbiter (
    .i_req     (req),
    .i_ptr     (r_ptr),
    .o_gnt     (w_arb_gnt),
    .o_gnt_idx (w_arb_idx)
  );

  always_comb begin
    w_sel_tag = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_arb_gnt[i]) w_sel_tag = req_tag[i*TAG_W +: TAG_W];
    end
  end

  // Tags are unique among valid buffers, so at most one entry can match.
  always_comb begin
    w_hit      = 1'b0;
    w_hit_buf  = '0;
    w_free     = 1'b0;
    w_free_buf = '0;
    for (int i = 0; i < NBUF; i++) begin
      if (r_valid[i] && (r_tags[i] == r_tag) && !w_hit) begin
        w_hit     = 1'b1;
        w_hit_buf = BUF_W'(i);
      end
      if (!r_valid[i] && !w_free) begin
        w_free     = 1'b1;
        w_free_buf = BUF_W'(i);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_req_any) w_state_nxt = ST_LOOKUP;
      ST_LOOKUP: begin
        if (w_hit)       w_state_nxt = ST_GRANT;
        else if (w_free) w_state_nxt = ST_FILL;
        else             w_state_nxt = ST_VICTIM;
      end
      ST_VICTIM: if (w_victim_done) w_state_nxt = ST_FILL;
      ST_FILL:   if (fill_ack) w_state_nxt = ST_GRANT;
      ST_GRANT:  w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr     <= '0;
      r_win_idx <= '0;
      r_tag     <= '0;
      r_buf     <= '0;
      r_hit     <= 1'b0;
      r_cnt     <= '0;
      r_valid   <= '0;
      for (int i = 0; i < NBUF; i++) r_tags[i] <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // A pending request takes priority; invalidation waits for an idle cycle without one.
          if (w_req_any) begin
            r_win_idx <= w_arb_idx;
            r_tag     <= w_sel_tag;
          end else if (inv_all) begin
            r_valid <= '0;
          end
        end
        ST_LOOKUP: begin
          r_hit <= w_hit;
          r_cnt <= '0;
          if (w_hit)       r_buf <= w_hit_buf;
          else if (w_free) r_buf <= w_free_buf;
        end
        ST_VICTIM: begin
          r_cnt <= r_cnt + 2'd1;
          if (w_victim_done) r_buf <= lfu_buf_num_replc;
        end
        ST_FILL: begin
          if (fill_ack) begin
            r_tags[r_buf]  <= r_tag;
            r_valid[r_buf] <= 1'b1;
          end
        end
        ST_GRANT: begin
          r_ptr <= (r_win_idx == PTR_W'(NREQ - 1)) ? '0 : r_win_idx + PTR_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Fill handshake: fill_req rises on entering FILL and holds, with fill_buf/fill_tag
  // stable, until the first rising edge at which fill_ack=1; that edge completes the fill.
  always_comb begin
    gnt               = '0;
    gnt_buf           = '0;
    gnt_hit           = 1'b0;
    fill_req          = 1'b0;
    fill_buf          = '0;
    fill_tag          = '0;
    lfu_new_buf_req   = 1'b0;
    lfu_ref_vld       = 1'b0;
    lfu_ref_buf_numbr = '0;
    busy              = (r_state != ST_IDLE);
    dbg_state         = r_state;
    case (r_state)
      ST_VICTIM: lfu_new_buf_req = (r_cnt == 2'd0);
      ST_FILL: begin
        fill_req = 1'b1;
        fill_buf = r_buf;
        fill_tag = r_tag;
      end
      ST_GRANT: begin
        for (int i = 0; i < NREQ; i++) gnt[i] = (r_win_idx == PTR_W'(i));
        gnt_buf           = r_buf;
        gnt_hit           = r_hit;
        lfu_ref_vld       = 1'b1;
        lfu_ref_buf_numbr = r_buf;
      end
      default: ;
    endcase
  end

endmodule
